// File: rtl/ppr_pkg.sv
// Shared constants and loader state encoding for the PPR graph loader and the
// random-walk engine that reads the CSR graph it builds.
package ppr_pkg;

  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 32;
  localparam int NODE_NUM   = 100;
  localparam int PTR_BASE   = 10;
  localparam int NEI_BASE   = 300;
  localparam int CNT_BASE   = 4400;
  localparam int CNT_DEPTH  = 3500;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLOSE_FIRST,
    CLOSE_LAST,
    FLUSH,
    CLEAR,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/ppr_graph_loader.sv
// Streams a src-sorted edge list into BRAM as a CSR graph (pointer table + neighbour list).
// Define GRAPH_LOADER_ZERO_COUNTERS_EN to also zero the visit-counter table before done.
module ppr_graph_loader #(
  parameter int ADDR_WIDTH = ppr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ppr_pkg::DATA_WIDTH,
  parameter int NODE_NUM   = ppr_pkg::NODE_NUM,
  parameter int PTR_BASE   = ppr_pkg::PTR_BASE,
  parameter int NEI_BASE   = ppr_pkg::NEI_BASE,
  parameter int MAX_EDGES  = 4096,
  parameter int CNT_BASE   = ppr_pkg::CNT_BASE,
  parameter int CNT_DEPTH  = ppr_pkg::CNT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_src,
  input  logic [DATA_WIDTH-1:0] s_dst,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] edge_count
);

  import ppr_pkg::*;

  localparam logic [DATA_WIDTH-1:0] NODE_LAST = DATA_WIDTH'(NODE_NUM);
  localparam logic [DATA_WIDTH-1:0] EDGE_CAP  = DATA_WIDTH'(MAX_EDGES);
  localparam logic [DATA_WIDTH-1:0] PTR_W     = DATA_WIDTH'(PTR_BASE);
  localparam logic [DATA_WIDTH-1:0] NEI_W     = DATA_WIDTH'(NEI_BASE);
  localparam logic [DATA_WIDTH-1:0] ONE_W     = DATA_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [DATA_WIDTH-1:0] a);
    return ADDR_WIDTH'(a);
  endfunction

  loader_state_t         state;
  logic [DATA_WIDTH-1:0] cur_node;
  logic [DATA_WIDTH-1:0] tgt_node;
  logic [DATA_WIDTH-1:0] edge_idx;
  logic [DATA_WIDTH-1:0] start_idx;
  logic                  flushing;

`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
  localparam logic [DATA_WIDTH-1:0] CNT_W    = DATA_WIDTH'(CNT_BASE);
  localparam logic [DATA_WIDTH-1:0] CNT_LAST = DATA_WIDTH'(CNT_DEPTH - 1);
  logic [DATA_WIDTH-1:0] clr_idx;
`endif

  logic src_bad;
  logic src_ahead;
  logic src_match;
  logic full;
  logic xfer;

  assign src_bad   = (s_src == '0) || (s_src < cur_node) || (s_src > NODE_LAST);
  assign src_ahead = (s_src > cur_node);
  assign src_match = (s_src == cur_node);
  assign full      = (edge_idx == EDGE_CAP);
  // An edge that would overflow the neighbour list is never written.
  assign xfer      = (state == LOAD) && s_valid && src_match && !full;

  always_comb begin
    s_ready    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    case (state)
      LOAD: begin
        s_ready = !s_valid || src_match;
        if (xfer) begin
          bram_we    = 1'b1;
          bram_addr  = to_addr(NEI_W + edge_idx);
          bram_wdata = s_dst;
        end
      end
      CLOSE_FIRST: begin
        bram_we    = 1'b1;
        bram_addr  = to_addr(PTR_W + (cur_node << 1));
        bram_wdata = NEI_W + start_idx;
      end
      CLOSE_LAST: begin
        bram_we    = 1'b1;
        bram_addr  = to_addr(PTR_W + (cur_node << 1) + ONE_W);
        bram_wdata = NEI_W + edge_idx;
      end
`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
      CLEAR: begin
        bram_we    = 1'b1;
        bram_addr  = to_addr(CNT_W + clr_idx);
        bram_wdata = '0;
      end
`endif
      default: ;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign edge_count = edge_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_node  <= '0;
      tgt_node  <= '0;
      edge_idx  <= '0;
      start_idx <= '0;
      flushing  <= 1'b0;
`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
      clr_idx   <= '0;
`endif
    end else begin
      case (state)
        // An error is only left by a fresh start, which restarts the load.
        IDLE, ERR: begin
          if (start) begin
            state     <= LOAD;
            cur_node  <= ONE_W;
            edge_idx  <= '0;
            start_idx <= '0;
            flushing  <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            if (src_bad) begin
              state <= ERR;
            end else if (src_ahead) begin
              tgt_node <= s_src;
              state    <= CLOSE_FIRST;
            end else if (full) begin
              state <= ERR;
            end else begin
              edge_idx <= edge_idx + ONE_W;
              if (s_last) begin
                flushing <= 1'b1;
                state    <= FLUSH;
              end
            end
          end
        end
        FLUSH:       state <= CLOSE_FIRST;
        CLOSE_FIRST: state <= CLOSE_LAST;
        CLOSE_LAST: begin
          cur_node  <= cur_node + ONE_W;
          start_idx <= edge_idx;
          if (flushing) begin
            if (cur_node == NODE_LAST) begin
`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
              clr_idx <= '0;
              state   <= CLEAR;
`else
              state   <= DONE;
`endif
            end else begin
              state <= CLOSE_FIRST;
            end
          end else if ((cur_node + ONE_W) == tgt_node) begin
            state <= LOAD;
          end else begin
            state <= CLOSE_FIRST;
          end
        end
`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
        CLEAR: begin
          clr_idx <= clr_idx + ONE_W;
          if (clr_idx == CNT_LAST) state <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppr_graph_loader.sv
// Directed bench for ppr_graph_loader with NODE_NUM=4, MAX_EDGES=6, CNT_DEPTH=8.
module tb_ppr_graph_loader;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_src;
  logic [DW-1:0] s_dst;
  logic          s_last;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] edge_count;

  ppr_graph_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_NUM(4), .PTR_BASE(10), .NEI_BASE(300),
    .MAX_EDGES(6), .CNT_BASE(4400), .CNT_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_src(s_src), .s_dst(s_dst), .s_last(s_last), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_wdata(bram_wdata), .busy(busy), .done(done),
    .err(err), .edge_count(edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [0:8191];
  int   cyc = 0;
  int   ptr_last_cyc = 0;
  int   done_cyc = 0;
  int   clr_cnt = 0;
  logic clr_req = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_req) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'hDEADBEEF;
      clr_cnt <= 0;
    end else if (bram_we) begin
      mem[bram_addr] <= bram_wdata;
      if (bram_addr == 13'd19) ptr_last_cyc <= cyc;
      if (bram_addr >= 13'd4400 && bram_addr < 13'd4408 && bram_wdata == '0) clr_cnt <= clr_cnt + 1;
    end
    if (done) done_cyc <= cyc;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic clear_mem();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
  endtask

  task automatic send(input int src, input int dst, input bit last, output int ptr_stalls);
    bit ok;
    ok = 1'b0; ptr_stalls = 0;
    s_valid = 1'b1; s_src = DW'(src); s_dst = DW'(dst); s_last = last;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (s_ready) begin tick(); ok = 1'b1; break; end
      if (bram_we) ptr_stalls++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL send_accept src=%0d: got no transfer, need transfer within 100 cycles", src); end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL done_timeout: got done=0, need done=1 within 300 cycles"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_src = '0; s_dst = '0; s_last = 1'b0;
    tick(); tick();
    vectors += 8;
    if (s_ready !== 1'b0)    begin miscompares++; $display("FAIL rst_s_ready got %b need 0", s_ready); end
    if (bram_we !== 1'b0)    begin miscompares++; $display("FAIL rst_bram_we got %b need 0", bram_we); end
    if (bram_addr !== '0)    begin miscompares++; $display("FAIL rst_bram_addr got %0d need 0", bram_addr); end
    if (bram_wdata !== '0)   begin miscompares++; $display("FAIL rst_bram_wdata got %0d need 0", bram_wdata); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy got %b need 0", busy); end
    if (done !== 1'b0)       begin miscompares++; $display("FAIL rst_done got %b need 0", done); end
    if (err !== 1'b0)        begin miscompares++; $display("FAIL rst_err got %b need 0", err); end
    if (edge_count !== '0)   begin miscompares++; $display("FAIL rst_edge_count got %0d need 0", edge_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int st;
    int exp_nei [4] = '{2, 3, 4, 1};
    int exp_ptr [8] = '{300, 302, 302, 303, 303, 303, 303, 304};
    clear_mem();
    pulse_start();
    send(1, 2, 0, st);
    send(1, 3, 0, st);
    start = 1'b1; tick(); start = 1'b0;
    send(2, 4, 0, st);
    send(4, 1, 1, st);
    wait_done();
    vectors++;
    if (edge_count !== 32'd4) begin miscompares++; $display("FAIL basic_edge_count_at_done got %0d need 4", edge_count); end
    tick();
    vectors += 3;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b need 0", done); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b need 0", busy); end
    if (edge_count !== 32'd4) begin miscompares++; $display("FAIL basic_edge_count_held got %0d need 4", edge_count); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[300 + i] !== DW'(exp_nei[i])) begin miscompares++; $display("FAIL basic_nei[%0d] got %0d need %0d", 300 + i, mem[300 + i], exp_nei[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[12 + i] !== DW'(exp_ptr[i])) begin miscompares++; $display("FAIL basic_ptr[%0d] got %0d need %0d", 12 + i, mem[12 + i], exp_ptr[i]); end
    end
`ifdef GRAPH_LOADER_ZERO_COUNTERS_EN
    vectors += 2;
    if (clr_cnt !== 8) begin miscompares++; $display("FAIL clear_writes got %0d need 8", clr_cnt); end
    if (done_cyc - ptr_last_cyc !== 9) begin miscompares++; $display("FAIL clear_done_gap got %0d need 9", done_cyc - ptr_last_cyc); end
`else
    vectors++;
    if (done_cyc - ptr_last_cyc !== 1) begin miscompares++; $display("FAIL done_gap got %0d need 1", done_cyc - ptr_last_cyc); end
`endif
  endtask

  task automatic test_stall();
    int st;
    int exp_ptr [8] = '{300, 301, 301, 301, 301, 302, 302, 303};
    clear_mem();
    pulse_start();
    send(1, 5, 0, st);
    send(3, 6, 0, st);
    vectors++;
    if (st !== 4) begin miscompares++; $display("FAIL stall_two_nodes got %0d need 4", st); end
    send(4, 7, 1, st);
    vectors++;
    if (st !== 2) begin miscompares++; $display("FAIL stall_one_node got %0d need 2", st); end
    wait_done();
    tick();
    vectors++;
    if (mem[301] !== 32'd6) begin miscompares++; $display("FAIL stall_nei301 got %0d need 6", mem[301]); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[12 + i] !== DW'(exp_ptr[i])) begin miscompares++; $display("FAIL stall_ptr[%0d] got %0d need %0d", 12 + i, mem[12 + i], exp_ptr[i]); end
    end
  endtask

  task automatic test_error_and_single();
    int st;
    clear_mem();
    pulse_start();
    send(3, 1, 0, st);
    s_valid = 1'b1; s_src = 32'd2; s_dst = 32'd9; #1;
    vectors += 2;
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL backward_ready got %b need 0", s_ready); end
    if (bram_we !== 1'b0) begin miscompares++; $display("FAIL backward_we got %b need 0", bram_we); end
    tick();
    s_valid = 1'b0;
    vectors += 4;
    if (err !== 1'b1)     begin miscompares++; $display("FAIL backward_err got %b need 1", err); end
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL err_ready got %b need 0", s_ready); end
    if (busy !== 1'b1)    begin miscompares++; $display("FAIL err_busy got %b need 1", busy); end
    if (mem[301] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL backward_nowrite got %0h need deadbeef", mem[301]); end
    tick(); tick();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b need 1", err); end
    pulse_start();
    vectors += 2;
    if (err !== 1'b0)  begin miscompares++; $display("FAIL restart_err got %b need 0", err); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b need 1", busy); end
    send(1, 1, 1, st);
    wait_done();
    tick();
    vectors += 3;
    if (edge_count !== 32'd1) begin miscompares++; $display("FAIL single_edge_count got %0d need 1", edge_count); end
    if (mem[300] !== 32'd1)   begin miscompares++; $display("FAIL single_nei got %0d need 1", mem[300]); end
    if (mem[12] !== 32'd300)  begin miscompares++; $display("FAIL single_ptr1_first got %0d need 300", mem[12]); end
    for (int i = 13; i < 20; i++) begin
      vectors++;
      if (mem[i] !== 32'd301) begin miscompares++; $display("FAIL single_ptr[%0d] got %0d need 301", i, mem[i]); end
    end
    pulse_start();
    s_valid = 1'b1; s_src = 32'd5; s_dst = 32'd0; tick();
    s_valid = 1'b0;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL src_over_range_err got %b need 1", err); end
    pulse_start();
    s_valid = 1'b1; s_src = 32'd0; tick();
    s_valid = 1'b0;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL src_zero_err got %b need 1", err); end
  endtask

  task automatic test_overflow();
    int st;
    pulse_start();
    for (int i = 0; i < 6; i++) send(1, 10 + i, 0, st);
    s_valid = 1'b1; s_src = 32'd1; s_dst = 32'd99; #1;
    vectors += 2;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready got %b need 1", s_ready); end
    if (bram_we !== 1'b0) begin miscompares++; $display("FAIL full_we got %b need 0", bram_we); end
    tick();
    s_valid = 1'b0;
    vectors += 2;
    if (err !== 1'b1) begin miscompares++; $display("FAIL full_err got %b need 1", err); end
    if (edge_count !== 32'd6) begin miscompares++; $display("FAIL full_edge_count got %0d need 6", edge_count); end
  endtask

  task automatic test_reset_mid_load();
    int st;
    pulse_start();
    send(1, 2, 0, st);
    s_valid = 1'b1; s_src = 32'd3; s_dst = 32'd4; tick();
    rst = 1'b1; #1;
    vectors += 5;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL midrst_busy got %b need 0", busy); end
    if (bram_we !== 1'b0)   begin miscompares++; $display("FAIL midrst_we got %b need 0", bram_we); end
    if (bram_addr !== '0)   begin miscompares++; $display("FAIL midrst_addr got %0d need 0", bram_addr); end
    if (s_ready !== 1'b0)   begin miscompares++; $display("FAIL midrst_ready got %b need 0", s_ready); end
    if (edge_count !== '0)  begin miscompares++; $display("FAIL midrst_edge_count got %0d need 0", edge_count); end
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    clear_mem();
    pulse_start();
    send(1, 1, 1, st);
    wait_done();
    tick();
    vectors += 3;
    if (edge_count !== 32'd1) begin miscompares++; $display("FAIL postrst_edge_count got %0d need 1", edge_count); end
    if (mem[13] !== 32'd301)  begin miscompares++; $display("FAIL postrst_ptr1_last got %0d need 301", mem[13]); end
    if (mem[19] !== 32'd301)  begin miscompares++; $display("FAIL postrst_ptr4_last got %0d need 301", mem[19]); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_error_and_single();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
